// File: rtl/multichannel_accumulator.sv
// CHANNELS independent accumulators (signed/unsigned, saturate/wrap) with a sequential dump readout.
// Optional macro ACC_STICKY_OVF_EN adds per-channel sticky overflow flags on ovf_sticky.
module multichannel_accumulator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned ACC_WIDTH  = 12,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned SIGN       = 0,
    parameter int unsigned OVERFLOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_oe,
    input  logic                  signal_dump,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  out_valid,
    output logic                  ovf,
    output logic                  attr_err,
    output logic                  busy
`ifdef ACC_STICKY_OVF_EN
    ,
    output logic [CHANNELS-1:0]   ovf_sticky
`endif
);

    // Two guard bits keep the unsigned sum (up to 2**ACC_WIDTH + 2**DATA_WIDTH) exact.
    localparam int unsigned SumW = ACC_WIDTH + 2;
    localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ATTR_WIDTH:0] ChanLim = (ATTR_WIDTH + 1)'(CHANNELS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);

    localparam logic signed [SumW-1:0] MaxVal = (SIGN != 0) ?
        {{(SumW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}} :
        {2'b00, {ACC_WIDTH{1'b1}}};
    localparam logic signed [SumW-1:0] MinVal = (SIGN != 0) ?
        {{(SumW - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}} :
        {SumW{1'b0}};

    typedef enum logic [0:0] {StIdle, StDump} state_e;

    state_e                 r_state, w_state_next;
    logic [IdxW-1:0]        r_index, w_index_next;
    logic [ACC_WIDTH-1:0]   r_acc [CHANNELS];
    logic [ACC_WIDTH-1:0]   r_data;
    logic [ATTR_WIDTH-1:0]  r_attr;
    logic                   r_valid, r_ovf, r_err;

    logic [IdxW-1:0]        w_ch;
    logic                   w_attr_ok, w_accept;
    logic signed [SumW-1:0] w_ext, w_opnd, w_base, w_sum;
    logic                   w_hi, w_lo;
    logic [ACC_WIDTH-1:0]   w_res;

    assign w_attr_ok = ({1'b0, attr_in} < ChanLim);
    assign w_ch      = attr_in[IdxW-1:0];
    assign w_accept  = signal_load && (r_state == StIdle) && w_attr_ok;

    always_comb begin
        w_ext = (SIGN != 0) ? {{(SumW - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in} :
                              {{(SumW - DATA_WIDTH){1'b0}}, data_in};
        w_opnd = signal_neg ? -w_ext : w_ext;
        w_base = '0;
        if (!signal_init) begin
            w_base = (SIGN != 0) ? {{2{r_acc[w_ch][ACC_WIDTH-1]}}, r_acc[w_ch]} :
                                   {2'b00, r_acc[w_ch]};
        end
        w_sum = w_base + w_opnd;
        w_hi  = (w_sum > MaxVal);
        w_lo  = (w_sum < MinVal);
        w_res = w_sum[ACC_WIDTH-1:0];
        if (OVERFLOW != 0) begin
            if (w_hi) begin
                w_res = MaxVal[ACC_WIDTH-1:0];
            end else if (w_lo) begin
                w_res = MinVal[ACC_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        unique case (r_state)
            StIdle: begin
                if (signal_dump) begin
                    w_state_next = StDump;
                    w_index_next = '0;
                end
            end
            StDump: begin
                if (r_index == LastIdx) begin
                    w_state_next = StIdle;
                end else begin
                    w_index_next = r_index + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_index <= '0;
            r_data  <= '0;
            r_attr  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            // Loads arriving during a dump are dropped without any flag.
            if (r_state == StDump) begin
                r_valid <= 1'b1;
                r_data  <= r_acc[r_index];
                r_attr  <= ATTR_WIDTH'(r_index);
            end else if (signal_load) begin
                if (w_attr_ok) begin
                    r_acc[w_ch] <= w_res;
                    r_valid     <= 1'b1;
                    r_data      <= w_res;
                    r_attr      <= attr_in;
                    r_ovf       <= w_hi | w_lo;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef ACC_STICKY_OVF_EN
    logic [CHANNELS-1:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (w_accept) begin
            // An init that itself overflows leaves the flag set.
            if (signal_init) begin
                r_sticky[w_ch] <= 1'b0;
            end
            if (w_hi || w_lo) begin
                r_sticky[w_ch] <= 1'b1;
            end
        end
    end

    assign ovf_sticky = r_sticky;
`endif

    assign data_out  = signal_oe ? r_data : '0;
    assign attr_out  = r_attr;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;
    assign attr_err  = r_err;
    assign busy      = (r_state == StDump);

endmodule

// File: tb/tb_multichannel_accumulator.sv
// Bench for multichannel_accumulator: three configurations share one stimulus stream and are
// compared every cycle against an integer model, plus literal checks from hand-worked sequences.
module tb_multichannel_accumulator;

    localparam int CH = 4;

    logic        clk, rst_n;
    logic        signal_load, signal_init, signal_neg, signal_oe, signal_dump;
    logic [7:0]  data_in;
    logic [3:0]  attr_in;

    logic [11:0] dout  [3];
    logic [3:0]  aout  [3];
    logic        vld   [3];
    logic        ovfo  [3];
    logic        erro  [3];
    logic        bsy   [3];
`ifdef ACC_STICKY_OVF_EN
    logic [3:0]  stk   [3];
`endif

    // Configurations: 0 = unsigned saturate, 1 = unsigned wrap, 2 = signed saturate.
    bit cfg_sgn [3] = '{1'b0, 1'b0, 1'b1};
    bit cfg_sat [3] = '{1'b1, 1'b0, 1'b1};

    int n_checks = 0;
    int n_errors = 0;

    multichannel_accumulator #(.SIGN(0), .OVERFLOW(1)) u_dut_us (
        .clk(clk), .rst_n(rst_n), .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_oe(signal_oe), .signal_dump(signal_dump),
        .data_in(data_in), .attr_in(attr_in), .data_out(dout[0]), .attr_out(aout[0]),
        .out_valid(vld[0]), .ovf(ovfo[0]), .attr_err(erro[0]), .busy(bsy[0])
`ifdef ACC_STICKY_OVF_EN
        , .ovf_sticky(stk[0])
`endif
    );

    multichannel_accumulator #(.SIGN(0), .OVERFLOW(0)) u_dut_uw (
        .clk(clk), .rst_n(rst_n), .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_oe(signal_oe), .signal_dump(signal_dump),
        .data_in(data_in), .attr_in(attr_in), .data_out(dout[1]), .attr_out(aout[1]),
        .out_valid(vld[1]), .ovf(ovfo[1]), .attr_err(erro[1]), .busy(bsy[1])
`ifdef ACC_STICKY_OVF_EN
        , .ovf_sticky(stk[1])
`endif
    );

    multichannel_accumulator #(.SIGN(1), .OVERFLOW(1)) u_dut_ss (
        .clk(clk), .rst_n(rst_n), .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_oe(signal_oe), .signal_dump(signal_dump),
        .data_in(data_in), .attr_in(attr_in), .data_out(dout[2]), .attr_out(aout[2]),
        .out_valid(vld[2]), .ovf(ovfo[2]), .attr_err(erro[2]), .busy(bsy[2])
`ifdef ACC_STICKY_OVF_EN
        , .ovf_sticky(stk[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, k, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: accumulator values kept as plain integers in range.
    int         m_acc   [3][CH];
    logic [11:0] m_data [3];
    int         m_attr  [3];
    bit         m_valid [3], m_ovf [3], m_err [3];
    bit [3:0]   m_stk   [3];
    bit         m_busy;
    int         m_idx;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < CH; c++) m_acc[k][c] = 0;
            m_data[k] = '0; m_attr[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
            m_stk[k] = '0;
        end
        m_busy = 0;
        m_idx  = 0;
    endtask

    task automatic model_load(input int k);
        int op, v, lo, hi, ch;
        bit o;
        ch = int'(attr_in);
        op = cfg_sgn[k] ? int'($signed(data_in)) : int'(data_in);
        if (signal_neg) op = -op;
        v  = signal_init ? op : m_acc[k][ch] + op;
        lo = cfg_sgn[k] ? -2048 : 0;
        hi = cfg_sgn[k] ? 2047 : 4095;
        o  = (v < lo) || (v > hi);
        if (o) begin
            if (cfg_sat[k]) begin
                v = (v < lo) ? lo : hi;
            end else begin
                v = v & 4095;
                if (cfg_sgn[k] && v >= 2048) v = v - 4096;
            end
        end
        m_acc[k][ch] = v;
        m_data[k]    = v[11:0];
        m_attr[k]    = ch;
        m_valid[k]   = 1;
        m_ovf[k]     = o;
        if (signal_init) m_stk[k][ch] = 1'b0;
        if (o) m_stk[k][ch] = 1'b1;
    endtask

    task automatic model_step();
        bit was_busy;
        int v;
        was_busy = m_busy;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
        end
        if (was_busy) begin
            for (int k = 0; k < 3; k++) begin
                v          = m_acc[k][m_idx];
                m_data[k]  = v[11:0];
                m_attr[k]  = m_idx;
                m_valid[k] = 1;
            end
            if (m_idx == CH - 1) m_busy = 0;
            else m_idx++;
        end else begin
            if (signal_load) begin
                if (int'(attr_in) < CH) begin
                    for (int k = 0; k < 3; k++) model_load(k);
                end else begin
                    for (int k = 0; k < 3; k++) m_err[k] = 1;
                end
            end
            if (signal_dump) begin
                m_busy = 1;
                m_idx  = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("cyc_data", k, 32'(dout[k]), signal_oe ? 32'(m_data[k]) : 0);
                check("cyc_attr", k, 32'(aout[k]), m_attr[k]);
                check("cyc_valid", k, 32'(vld[k]), 32'(m_valid[k]));
                check("cyc_ovf", k, 32'(ovfo[k]), 32'(m_ovf[k]));
                check("cyc_err", k, 32'(erro[k]), 32'(m_err[k]));
                check("cyc_busy", k, 32'(bsy[k]), 32'(m_busy));
`ifdef ACC_STICKY_OVF_EN
                check("cyc_sticky", k, 32'(stk[k]), 32'(m_stk[k]));
`endif
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; returns 1 unit after the next edge.
    task automatic step(input bit ld, input bit ini, input bit ng, input bit dmp,
                        input logic [7:0] d, input logic [3:0] a);
        signal_load = ld; signal_init = ini; signal_neg = ng; signal_dump = dmp;
        data_in = d; attr_in = a;
        @(posedge clk);
        #1;
        signal_load = 0; signal_init = 0; signal_neg = 0; signal_dump = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_data", 0, 32'(dout[0]), 0);
        check("rst_valid", 0, 32'(vld[0]), 0);
        check("rst_busy", 0, 32'(bsy[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int ed [4];

    initial begin
        rst_n = 1'b0;
        signal_load = 0; signal_init = 0; signal_neg = 0; signal_dump = 0; signal_oe = 1;
        data_in = '0; attr_in = '0;
        @(posedge clk);
        #1;
        check("reset_data", 0, 32'(dout[0]), 0);
        check("reset_attr", 0, 32'(aout[0]), 0);
        check("reset_ovf", 0, 32'(ovfo[0]), 0);
        check("reset_err", 0, 32'(erro[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Running sum on channel 0.
        step(1, 1, 0, 0, 8'd1, 4'd0);
        check("sum1", 0, 32'(dout[0]), 1);
        check("sum1_valid", 0, 32'(vld[0]), 1);
        step(1, 0, 0, 0, 8'd2, 4'd0);
        check("sum3", 0, 32'(dout[0]), 3);
        step(1, 0, 0, 0, 8'd3, 4'd0);
        check("sum6", 0, 32'(dout[0]), 6);
        step(1, 0, 0, 0, 8'd4, 4'd0);
        check("sum10", 0, 32'(dout[0]), 10);
        check("sum10_attr", 0, 32'(aout[0]), 0);

        // Dump readout; loads during busy are dropped.
        do_reset();
        step(1, 1, 0, 0, 8'd5, 4'd1);
        step(1, 1, 0, 0, 8'd7, 4'd2);
        step(1, 0, 0, 0, 8'd1, 4'd1);
        check("ch1_6", 0, 32'(dout[0]), 6);
        check("ch1_attr", 0, 32'(aout[0]), 1);
        step(0, 0, 0, 1, 8'd0, 4'd0);
        check("dump_busy0", 0, 32'(bsy[0]), 1);
        ed = '{0, 6, 7, 0};
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 8'd9, 4'd0);
            check("dump_data", 0, 32'(dout[0]), ed[i]);
            check("dump_attr", 0, 32'(aout[0]), i);
            check("dump_valid", 0, 32'(vld[0]), 1);
            check("dump_busy", 0, 32'(bsy[0]), (i < 3) ? 1 : 0);
        end
        step(1, 0, 0, 0, 8'd0, 4'd0);
        check("dropped_load", 0, 32'(dout[0]), 0);
        // Load in the same cycle as dump is visible in that dump.
        step(1, 1, 0, 1, 8'd11, 4'd2);
        check("ld_dump", 0, 32'(dout[0]), 11);
        ed = '{0, 6, 11, 0};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 8'd0, 4'd0);
            check("dump2_data", 0, 32'(dout[0]), ed[i]);
        end

        // Unsigned overflow: saturate versus wrap.
        do_reset();
        step(1, 1, 0, 0, 8'd255, 4'd0);
        check("init255", 0, 32'(dout[0]), 255);
        repeat (15) step(1, 0, 0, 0, 8'd255, 4'd0);
        check("sum4080", 0, 32'(dout[0]), 4080);
        check("sum4080_ovf", 0, 32'(ovfo[0]), 0);
        step(1, 0, 0, 0, 8'd255, 4'd0);
        check("sat4095", 0, 32'(dout[0]), 4095);
        check("sat_ovf", 0, 32'(ovfo[0]), 1);
        check("wrap239", 1, 32'(dout[1]), 239);
        check("wrap_ovf", 1, 32'(ovfo[1]), 1);
        step(1, 0, 1, 0, 8'd255, 4'd0);
        check("neg3840", 0, 32'(dout[0]), 3840);
        check("neg3840_ovf", 0, 32'(ovfo[0]), 0);
`ifdef ACC_STICKY_OVF_EN
        check("sticky_set", 0, 32'(stk[0][0]), 1);
`endif
        step(1, 1, 0, 0, 8'd1, 4'd0);
`ifdef ACC_STICKY_OVF_EN
        check("sticky_clr", 0, 32'(stk[0][0]), 0);
`endif
        step(1, 0, 1, 0, 8'd2, 4'd0);
        check("under0", 0, 32'(dout[0]), 0);
        check("under_ovf", 0, 32'(ovfo[0]), 1);
        step(0, 0, 0, 0, 8'd0, 4'd0);
        check("ovf_pulse", 0, 32'(ovfo[0]), 0);
        check("hold_valid", 0, 32'(vld[0]), 0);

        // Signed operands.
        do_reset();
        step(1, 1, 0, 0, 8'h80, 4'd0);
        check("s_m128", 2, 32'(dout[2]), 32'h0F80);
        step(1, 0, 1, 0, 8'h80, 4'd0);
        check("s_zero", 2, 32'(dout[2]), 0);
        step(1, 1, 1, 0, 8'h80, 4'd0);
        check("s_p128", 2, 32'(dout[2]), 32'h0080);
        check("s_p128_ovf", 2, 32'(ovfo[2]), 0);

        // Out-of-range channel.
        step(1, 1, 0, 0, 8'd1, 4'd5);
        check("attr_err", 0, 32'(erro[0]), 1);
        check("attr_err_valid", 0, 32'(vld[0]), 0);
        step(0, 0, 0, 0, 8'd0, 4'd0);
        check("attr_err_pulse", 0, 32'(erro[0]), 0);

        // Output enable gating.
        signal_oe = 1'b0;
        step(1, 1, 0, 0, 8'd3, 4'd1);
        check("oe_data", 0, 32'(dout[0]), 0);
        check("oe_valid", 0, 32'(vld[0]), 1);
        check("oe_attr", 0, 32'(aout[0]), 1);
        signal_oe = 1'b1;
        #1;
        check("oe_restore", 0, 32'(dout[0]), 3);

        // Reset in the middle of a dump.
        for (int c = 0; c < CH; c++) step(1, 1, 0, 0, 8'(21 + c), 4'(c));
        step(0, 0, 0, 1, 8'd0, 4'd0);
        step(0, 0, 0, 0, 8'd0, 4'd0);
        check("pre_rst_dump", 0, 32'(dout[0]), 21);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 0, 32'(dout[0]), 0);
        check("mid_rst_valid", 0, 32'(vld[0]), 0);
        check("mid_rst_busy", 0, 32'(bsy[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 1, 8'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 8'd0, 4'd0);
            check("post_rst_data", 0, 32'(dout[0]), 0);
            check("post_rst_attr", 0, 32'(aout[0]), i);
            check("post_rst_valid", 0, 32'(vld[0]), 1);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
